bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
// PURPOSE
//  Multi-digit packed-BCD subtractor. Computes |A - B| and a sign flag.
//  Processes one decimal digit per clock, least-significant digit first, using a borrow chain.
//  When A < B, it runs a second ten's-complement pass to produce the magnitude.
//  It is the inverse-operation companion to the combinational bcd_adder, for multi-digit datapaths.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); operand width = 4*DIGITS
// PORTS
//  clk    in   1         rising-edge clock
//  rst    in   1         synchronous, active-high reset
//  start  in   1         request; sampled only in IDLE
//  A      in   4*DIGITS  minuend, packed BCD, digit 0 = A[3:0]
//  B      in   4*DIGITS  subtrahend, packed BCD
//  busy   out  1         high in SUB and COMP
//  done   out  1         one-cycle pulse; D/neg/err valid from this cycle
//  D      out  4*DIGITS  |A-B|, packed BCD; held until the next accepted start
//  neg    out  1         1 when A < B; 0 for a zero result
//  err    out  1         invalid-digit flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, D=0, neg=0, err=0; internal idx/borrow cleared.
//   Reset wins over every other event, including mid-SUB or mid-COMP; no done pulse follows.
//  FSM states: IDLE, SUB, COMP, DONE.
//   IDLE -> SUB when start=1. On that edge: latch A and B, idx=0, borrow=0, clear D/neg/err.
//   SUB: one digit per edge: t = a[idx] - b[idx] - borrow (signed, 5-bit).
//    If t<0: D[idx]=t+10 and borrow=1; else D[idx]=t and borrow=0. Then idx++.
//    On the last digit (idx=DIGITS-1):
//     - if the final borrow is 1: go to COMP, set neg=1, idx=0, borrow=0;
//     - otherwise go to DONE.
//   COMP: per edge: t = 0 - D[idx] - borrow, using the same correct/borrow rule; write D[idx]; idx++.
//    After idx=DIGITS-1, go to DONE. The final borrow is discarded.
//   DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
//  Latency, counting the start-sampling edge as edge 0:
//   A>=B: done high after edge DIGITS.  A<B: done high after edge 2*DIGITS.
//  start while busy or in DONE: ignored and not queued. Latched operands are isolated from A/B changes mid-operation.
//  start in the same IDLE cycle that done falls: accepted normally (back-to-back operation).
//  D is updated in place digit by digit during SUB/COMP; it is valid only from done onward.
//  Result is zero (A==B): D=0, neg=0, COMP is not entered.
// CONFIGURATION
//  Macro BCD_SUB_DIGIT_CHECK_EN.
//   Defined: on accepted start, any A or B digit >9 sets err=1.
//    The operation then skips SUB/COMP: IDLE->DONE, with D=0, neg=0 and done pulsing on edge 1.
//    err holds until the next accepted start or rst.
//   Undefined: err is tied to 0. Invalid digits pass through the same SUB/COMP arithmetic unchecked.
//    No extra logic is present.
// TESTING (DIGITS=4 unless noted)
//  1. A=16'h5432, B=16'h1234, start 1 cycle
//     -> busy for 4 cycles, done after edge 4, D=16'h4198, neg=0, err=0.
//  2. A=16'h1234, B=16'h5432
//     -> COMP entered; done after edge 8, D=16'h4198, neg=1.
//     Also A=B=16'h0000 -> D=0, neg=0, done after edge 4.
//  3. A=16'h1000, B=16'h0001 (borrow ripple)
//     -> D=16'h0999, neg=0.
//     Also A=16'h0000, B=16'h9999 -> D=16'h9999, neg=1.
//  4. start re-pulsed with new A/B on edge 2 of an operation
//     -> ignored; result matches the first operands.
//     Start asserted on the IDLE cycle after done -> second operation accepted and correct.
//  5. rst asserted on edge 2 of a COMP pass
//     -> next cycle: busy=0, done=0, D=0, neg=0; no done pulse until a new start.
//  6. With BCD_SUB_DIGIT_CHECK_EN: A=16'h00A0, B=16'h0001
//     -> err=1, D=0, neg=0, done after edge 1.
//     Without the macro: err stays 0 for the same stimulus.

Source files
------------

// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for bcd_serial_subtractor.
// The master side drives a request, and the slave side returns |A-B| with its flags.
interface bcd_serial_subtractor_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   D;
    logic                  neg;
    logic                  err;

    modport master (
        output start, A, B,
        input  busy, done, D, neg, err
    );

    modport slave (
        input  start, A, B,
        output busy, done, D, neg, err
    );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Serial packed-BCD subtractor: |A-B| one digit per clock, LSD first, with a ten's-complement pass when A<B.
// Optional macro BCD_SUB_DIGIT_CHECK_EN flags operands that contain digits >9 and skips the arithmetic.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last answer
// SUB   | A-B, one digit per cycle, borrow chain
// COMP  | 0-D pass that turns a negative ten's-complement result into a magnitude
// DONE  | one-cycle done pulse
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    bcd_serial_subtractor_if.slave      bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;

    state_t             state, state_n;
    logic [W-1:0]       a_q, b_q, d_q;
    logic [IDX_W-1:0]   idx;
    logic               borrow;
    logic               neg_q;
    logic               last;
    logic [3:0]         opnd_a, opnd_b, t_fix;
    logic [4:0]         t;
    logic               t_borrow;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic               err_q;
    logic               digit_bad;
`endif

    assign last = (idx == IDX_W'(DIGITS - 1));

    // Operands are shifted right each step, so digit 0 of every register is always the current digit.
    always_comb begin
        opnd_a   = (state == COMP) ? 4'd0 : a_q[3:0];
        opnd_b   = (state == COMP) ? d_q[3:0] : b_q[3:0];
        t        = {1'b0, opnd_a} - {1'b0, opnd_b} - {4'd0, borrow};
        t_borrow = t[4];
        t_fix    = t_borrow ? (t[3:0] + 4'd10) : t[3:0];
    end

`ifdef BCD_SUB_DIGIT_CHECK_EN
    always_comb begin
        digit_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.A[4*i +: 4] > 4'd9 || bus.B[4*i +: 4] > 4'd9)
                digit_bad = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.start) state_n = SUB;
            SUB: begin
`ifdef BCD_SUB_DIGIT_CHECK_EN
                // A rejected operand pair spends one cycle here so done lands on edge 1.
                if (err_q)     state_n = DONE;
                else if (last) state_n = t_borrow ? COMP : DONE;
`else
                if (last)      state_n = t_borrow ? COMP : DONE;
`endif
            end
            COMP: if (last) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            neg_q  <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q    <= bus.A;
                    b_q    <= bus.B;
                    d_q    <= '0;
                    idx    <= '0;
                    borrow <= 1'b0;
                    neg_q  <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    err_q  <= digit_bad;
`endif
                end
                SUB: begin
`ifdef BCD_SUB_DIGIT_CHECK_EN
                    if (!err_q) begin
`else
                    begin
`endif
                        d_q    <= W'({t_fix, d_q} >> 4);
                        a_q    <= a_q >> 4;
                        b_q    <= b_q >> 4;
                        borrow <= t_borrow;
                        idx    <= idx + 1'b1;
                        if (last) begin
                            idx    <= '0;
                            borrow <= 1'b0;
                            if (t_borrow) neg_q <= 1'b1;
                        end
                    end
                end
                COMP: begin
                    d_q    <= W'({t_fix, d_q} >> 4);
                    borrow <= t_borrow;
                    idx    <= idx + 1'b1;
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SUB) || (state == COMP);
    assign bus.done = (state == DONE);
    assign bus.D    = d_q;
    assign bus.neg  = neg_q;
`ifdef BCD_SUB_DIGIT_CHECK_EN
    assign bus.err  = err_q;
`else
    assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4) with hand-computed results.
module tb_bcd_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts an operation from IDLE, optionally re-pulses start with other operands
    // on edge 2, and returns one cycle after the done pulse.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input logic exp_neg, input logic exp_err,
                          input int exp_lat, input bit repulse);
        int n;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (n < 40 && !bus.done) begin
            if (repulse && n == 1) begin
                bus.A = 16'h1111;
                bus.B = 16'h2222;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_D"}, 32'(bus.D), 32'(exp_d));
        check({tag, "_neg"}, 32'(bus.neg), 32'(exp_neg));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        check({tag, "_D_hold"}, 32'(bus.D), 32'(exp_d));
    endtask

    initial begin
        bit seen_done;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_D", 32'(bus.D), 32'd0);
        check("rst_neg", 32'(bus.neg), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        run_op("pos", 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4, 1'b0);
        run_op("negv", 16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8, 1'b0);
        run_op("zero", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
        run_op("ripple", 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4, 1'b0);
        run_op("neg_max", 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8, 1'b0);
        run_op("pos_max", 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4, 1'b0);
        run_op("neg_one", 16'h0500, 16'h0501, 16'h0001, 1'b1, 1'b0, 8, 1'b0);
        run_op("equal", 16'h7381, 16'h7381, 16'h0000, 1'b0, 1'b0, 4, 1'b0);
        run_op("repulse", 16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4, 1'b1);
        run_op("b2b", 16'h2000, 16'h0999, 16'h1001, 1'b0, 1'b0, 4, 1'b0);

`ifdef BCD_SUB_DIGIT_CHECK_EN
        run_op("baddigit", 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("err_clear", 16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0, 4, 1'b0);
`else
        run_op("baddigit", 16'h00A0, 16'h0001, 16'h0099, 1'b0, 1'b0, 4, 1'b0);
`endif

        // Reset on edge 2 of the COMP pass (edge 6 of the operation)
        bus.A = 16'h1234;
        bus.B = 16'h5432;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_D", 32'(bus.D), 32'd0);
        check("midrst_neg", 32'(bus.neg), 32'd0);
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        run_op("after_rst", 16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
